pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Game/score controller downstream of the ball block. Samples ball position each frame,
//  detects goals at the left/right field edges, keeps both scores, and sequences
//  serve / play / pause / game-over. Drives a ball-reset request (OR'd into the ball
//  block reset) and score/state outputs for the text/score renderer.
// PARAMETERS
//  GOAL_LEFT_X   10'd33   left goal line; ball left edge <= this -> player 2 scores
//  GOAL_RIGHT_X  10'd596  right goal line; ball right edge >= this -> player 1 scores
//  WIN_SCORE     4'd7     score that ends the game (1..15)
//  PAUSE_FRAMES  8'd60    frames ball is held at centre after a goal (1..255)
// PORTS
//  frame_clk  in   1   frame-rate clock (vsync); all state changes on rising edge
//  Reset      in   1   asynchronous, active-low reset
//  Start      in   1   start/serve key level (high while pressed), rising-edge detected
//  BallX      in   10  ball centre X (ball block output)
//  BallY      in   10  ball centre Y (unused for goals; kept for state readout)
//  BallS      in   10  ball half-size
//  BallReset  out  1   high = hold ball at centre (active-high, to ball block Reset)
//  Score1     out  4   player 1 (left paddle) score
//  Score2     out  4   player 2 (right paddle) score
//  GameOver   out  1   high in OVER state
//  Winner     out  2   00 none, 01 player 1, 10 player 2
//  GameState  out  2   00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
// BEHAVIOUR
//  Reset (low, async): state IDLE, Score1=Score2=0, pause counter=0, Start_d=0,
//   BallReset=1, GameOver=0, Winner=00. All outputs registered or decoded from regs only.
//  start_rise = Start & ~Start_d; Start_d <= Start every edge.
//  Goal compare in 11 bits, no wrap: goal_l = ({1'b0,BallX} <= GOAL_LEFT_X + BallS);
//   goal_r = ({1'b0,BallX} + BallS >= GOAL_RIGHT_X). goal_l has priority if both true.
//  IDLE : BallReset=1. start_rise -> PLAY.
//  PLAY : BallReset=0. goal_l -> Score2+1; goal_r -> Score1+1 (same edge).
//         If incremented score == WIN_SCORE -> OVER, Winner set; else -> PAUSE, cnt=0.
//         No goal -> stay. Exactly one score increment per goal event.
//  PAUSE: BallReset=1; cnt+1 per frame; at cnt==PAUSE_FRAMES-1 -> PLAY. Goals ignored.
//  OVER : BallReset=1, GameOver=1, Winner held, scores frozen. start_rise -> IDLE with
//         Score1=Score2=0, Winner=00 (new game needs a second Start press).
//  Latency: goal frame edge -> score/state visible 1 edge later; BallReset rises same edge
//   as PAUSE entry, so ball is centred before next PLAY frame.
//  Start held continuously counts as a single press; press in PLAY/PAUSE ignored.
//  Score never exceeds WIN_SCORE; no wrap. Reset mid-PAUSE/OVER aborts to IDLE immediately.
// TESTING
//  Reset low mid-game -> next sample all regs 0, GameState=00, BallReset=1.
//  IDLE, Start pulse, BallX=320,S=4 -> GameState=01, BallReset=0, scores unchanged.
//  PLAY, BallX=30,S=4 one frame -> Score2=1, GameState=10; after 60 frames -> 01.
//  PLAY, BallX=593,S=4 -> Score1+1; BallX=2,S=4 (underflow case) -> goal_l, Score2+1.
//  Score1=6, right goal -> Score1=7, GameState=11, GameOver=1, Winner=01; Start -> IDLE, 0/0.
//  Start held high across IDLE->PLAY->PAUSE -> single transition only; goals in PAUSE ignored.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// ----------------------------------------------------------------------------
// pong_game_ctrl
//   Game and score controller that sits downstream of the ball block. It is
//   clocked once per frame. On each frame it samples the ball position, spots
//   goals at the left and right field edges, and keeps both players' scores.
//   It also runs the serve / play / pause / game-over sequence.
//
// Ports
//   frame_clk  in   1   frame-rate clock (vsync); all state changes on rising edge
//   Reset      in   1   asynchronous active-low reset
//   Start      in   1   start/serve key level; rising edge is the "press" event
//   BallX      in  10   ball centre X
//   BallY      in  10   ball centre Y (not used for goal detection)
//   BallS      in  10   ball half-size
//   BallReset  out  1   high holds the ball at centre (drives ball block reset)
//   Score1     out  4   player 1 (left paddle) score
//   Score2     out  4   player 2 (right paddle) score
//   GameOver   out  1   high while in OVER
//   Winner     out  2   00 none, 01 player 1, 10 player 2
//   GameState  out  2   00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
// ----------------------------------------------------------------------------
module pong_game_ctrl #(
    parameter logic [9:0] GOAL_LEFT_X  = 10'd33,
    parameter logic [9:0] GOAL_RIGHT_X = 10'd596,
    parameter logic [3:0] WIN_SCORE    = 4'd7,
    parameter logic [7:0] PAUSE_FRAMES = 8'd60
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] BallS,
    output logic       BallReset,
    output logic [3:0] Score1,
    output logic [3:0] Score2,
    output logic       GameOver,
    output logic [1:0] Winner,
    output logic [1:0] GameState
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    state_t      r_state,   w_state_nxt;
    logic [3:0]  r_score1,  w_score1_nxt;
    logic [3:0]  r_score2,  w_score2_nxt;
    logic [1:0]  r_winner,  w_winner_nxt;
    logic [7:0]  r_cnt,     w_cnt_nxt;
    logic        r_start_d;

    logic        w_start_rise;
    logic        w_goal_l;
    logic        w_goal_r;
    logic [3:0]  w_inc1;
    logic [3:0]  w_inc2;
    logic        w_unused_bally;

    // BallY is not needed for goals; it is folded here so it is not left dangling.
    assign w_unused_bally = ^BallY;

    assign w_start_rise = Start & ~r_start_d;

    // The compare is done in 11 bits so that a ball close to x=0 (BallX < BallS)
    // cannot wrap around and hide a left goal.
    assign w_goal_l = ({1'b0, BallX} <= ({1'b0, GOAL_LEFT_X} + {1'b0, BallS}));
    assign w_goal_r = (({1'b0, BallX} + {1'b0, BallS}) >= {1'b0, GOAL_RIGHT_X});

    assign w_inc1 = r_score1 + 4'd1;
    assign w_inc2 = r_score2 + 4'd1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_score1  <= '0;
            r_score2  <= '0;
            r_winner  <= '0;
            r_cnt     <= '0;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_score1  <= w_score1_nxt;
            r_score2  <= w_score2_nxt;
            r_winner  <= w_winner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_start_d <= Start;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_score1_nxt = r_score1;
        w_score2_nxt = r_score2;
        w_winner_nxt = r_winner;
        w_cnt_nxt    = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt = S_PLAY;
                end
            end

            S_PLAY: begin
                // The left goal wins if both goals fire, so each event gives
                // exactly one increment.
                if (w_goal_l) begin
                    w_score2_nxt = w_inc2;
                    if (w_inc2 == WIN_SCORE) begin
                        w_state_nxt  = S_OVER;
                        w_winner_nxt = 2'b10;
                    end else begin
                        w_state_nxt = S_PAUSE;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_goal_r) begin
                    w_score1_nxt = w_inc1;
                    if (w_inc1 == WIN_SCORE) begin
                        w_state_nxt  = S_OVER;
                        w_winner_nxt = 2'b01;
                    end else begin
                        w_state_nxt = S_PAUSE;
                        w_cnt_nxt   = '0;
                    end
                end
            end

            S_PAUSE: begin
                if (r_cnt == PAUSE_FRAMES - 8'd1) begin
                    w_state_nxt = S_PLAY;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            S_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt  = S_IDLE;
                    w_score1_nxt = '0;
                    w_score2_nxt = '0;
                    w_winner_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs are decoded from registers only. Because BallReset is decoded
    // from the state, it rises on the same edge that enters PAUSE.
    // ------------------------------------------------------------------
    assign GameState = r_state;
    assign BallReset = (r_state != S_PLAY);
    assign GameOver  = (r_state == S_OVER);
    assign Score1    = r_score1;
    assign Score2    = r_score2;
    assign Winner    = r_winner;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pong_game_ctrl
//   Self-checking bench for pong_game_ctrl. It first runs a directed game
//   scenario and then a randomized frame stream. Every frame is compared with
//   a behavioural game model.
// ----------------------------------------------------------------------------
module tb_pong_game_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallS;
    logic       BallReset;
    logic [3:0] Score1;
    logic [3:0] Score2;
    logic       GameOver;
    logic [1:0] Winner;
    logic [1:0] GameState;

    pong_game_ctrl #(
        .GOAL_LEFT_X  (10'd33),
        .GOAL_RIGHT_X (10'd596),
        .WIN_SCORE    (4'd7),
        .PAUSE_FRAMES (8'd60)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .Start     (Start),
        .BallX     (BallX),
        .BallY     (BallY),
        .BallS     (BallS),
        .BallReset (BallReset),
        .Score1    (Score1),
        .Score2    (Score2),
        .GameOver  (GameOver),
        .Winner    (Winner),
        .GameState (GameState)
    );

    always #5 frame_clk = ~frame_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- behavioural game model ----------------
    // Modes: 0 idle, 1 play, 2 pause, 3 over
    int m_mode, m_s1, m_s2, m_win, m_pause_left, m_prev_start;

    task automatic model_reset();
        m_mode = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
        m_pause_left = 0; m_prev_start = 0;
    endtask

    task automatic model_step(input int st, input int bx, input int bs);
        bit pressed, left_goal, right_goal;
        pressed      = (st != 0) && (m_prev_start == 0);
        m_prev_start = st;
        left_goal    = bx <= 33 + bs;
        right_goal   = bx + bs >= 596;
        case (m_mode)
            0: if (pressed) m_mode = 1;
            1: begin
                if (left_goal) begin
                    m_s2++;
                    if (m_s2 == 7) begin m_mode = 3; m_win = 2; end
                    else begin m_mode = 2; m_pause_left = 60; end
                end else if (right_goal) begin
                    m_s1++;
                    if (m_s1 == 7) begin m_mode = 3; m_win = 1; end
                    else begin m_mode = 2; m_pause_left = 60; end
                end
            end
            2: begin
                m_pause_left--;
                if (m_pause_left == 0) m_mode = 1;
            end
            default: if (pressed) begin
                m_mode = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
            end
        endcase
    endtask

    task automatic check_all();
        check("state",     int'(GameState), m_mode);
        check("ballreset", int'(BallReset), (m_mode != 1) ? 1 : 0);
        check("score1",    int'(Score1),    m_s1);
        check("score2",    int'(Score2),    m_s2);
        check("gameover",  int'(GameOver),  (m_mode == 3) ? 1 : 0);
        check("winner",    int'(Winner),    m_win);
    endtask

    // The inputs are driven just after a falling edge. One rising edge is
    // applied, and the results are checked on the next falling edge.
    task automatic frame(input int st, input int bx, input int bs);
        Start = st[0];
        BallX = bx[9:0];
        BallS = bs[9:0];
        BallY = 10'($urandom_range(0, 479));
        @(posedge frame_clk);
        model_step(st, bx, bs);
        @(negedge frame_clk);
        check_all();
    endtask

    task automatic wait_pause();
        // Goal-looking positions during the pause must have no effect.
        repeat (60) frame(0, 2, 4);
    endtask

    task automatic async_reset(input string tag);
        #2 Reset = 1'b0;
        #1;
        model_reset();
        check({tag, "_state"},  int'(GameState), 0);
        check({tag, "_brst"},   int'(BallReset), 1);
        check({tag, "_s1"},     int'(Score1),    0);
        check({tag, "_s2"},     int'(Score2),    0);
        check({tag, "_winner"}, int'(Winner),    0);
        @(negedge frame_clk);
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0;
        BallX = 10'd320; BallY = 10'd240; BallS = 10'd4;
        model_reset();
        #1 Reset = 1'b0;
        #2;
        check_all();
        check("rst_gameover", int'(GameOver), 0);
        @(negedge frame_clk);
        Reset = 1'b1;

        // Serve
        frame(1, 320, 4);
        check("serve_state", int'(GameState), 1);
        check("serve_brst",  int'(BallReset), 0);

        // Left goal: enter pause, and return to play after 60 frames
        frame(0, 30, 4);
        check("lgoal_s2",    int'(Score2),    1);
        check("lgoal_state", int'(GameState), 2);
        repeat (59) frame(0, 320, 4);
        check("pause_59",    int'(GameState), 2);
        frame(0, 320, 4);
        check("pause_done",  int'(GameState), 1);

        // Right goal. Start is held through the pause and must be ignored.
        frame(0, 593, 4);
        check("rgoal_s1",    int'(Score1),    1);
        repeat (60) frame(1, 2, 4);
        check("held_s2",     int'(Score2),    1);
        check("held_state",  int'(GameState), 1);

        // BallX smaller than BallS must still count as a left goal.
        frame(0, 2, 4);
        check("under_s2",    int'(Score2),    2);

        // Player 1 goes on to win
        repeat (5) begin
            wait_pause();
            frame(0, 593, 4);
        end
        wait_pause();
        check("pre_win_s1",  int'(Score1),    6);
        frame(0, 593, 4);
        check("win_s1",      int'(Score1),    7);
        check("win_state",   int'(GameState), 3);
        check("win_over",    int'(GameOver),  1);
        check("win_winner",  int'(Winner),    1);
        frame(0, 30, 4);
        check("over_frozen", int'(Score2),    2);
        frame(1, 320, 4);
        check("new_state",   int'(GameState), 0);
        check("new_s1",      int'(Score1),    0);
        frame(1, 320, 4);
        check("hold_idle",   int'(GameState), 0);
        frame(0, 320, 4);
        frame(1, 320, 4);
        check("replay",      int'(GameState), 1);
        frame(1, 30, 4);
        frame(1, 320, 4);
        check("held_pause",  int'(GameState), 2);

        async_reset("midpause");

        // Randomized frame stream
        for (int i = 0; i < 3000; i++) begin
            int st, bx, bs, r;
            r  = int'($urandom_range(0, 15));
            bs = int'($urandom_range(0, 15));
            if (r < 2)      bx = int'($urandom_range(0, 45));
            else if (r < 4) bx = int'($urandom_range(580, 1023));
            else            bx = int'($urandom_range(50, 570));
            st = ($urandom_range(0, 7) == 0) ? 1 : 0;
            frame(st, bx, bs);
            if ($urandom_range(0, 999) == 0) async_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
